// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and transmitter-side signals around the UART TX arbiter.
// The slave modport is the arbiter; the master modport is whatever drives requests and the transmitter status.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]   i_req_valid;
    logic [8*N_REQ-1:0] i_req_byte;
    logic [N_REQ-1:0]   o_req_ready;
    logic [N_REQ-1:0]   o_req_done;
    logic               o_timeout;
    logic               o_busy;
    logic [IDW-1:0]     o_grant_id;
    logic               o_tx_dv;
    logic [7:0]         o_tx_byte;
    logic               i_tx_active;
    logic               i_tx_done;

    modport master (
        output i_req_valid, i_req_byte, i_tx_active, i_tx_done,
        input  o_req_ready, o_req_done, o_timeout, o_busy, o_grant_id, o_tx_dv, o_tx_byte
    );

    modport slave (
        input  i_req_valid, i_req_byte, i_tx_active, i_tx_done,
        output o_req_ready, o_req_done, o_timeout, o_busy, o_grant_id, o_tx_dv, o_tx_byte
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte requesters,
// with done-edge completion, an inter-frame gap and a watchdog for a stuck transmitter.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input logic            i_clk,
    input logic            i_rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0]  GAP_LAST     = GW'(GAP_CYCLES);
    localparam logic [IDW-1:0] ID_LAST      = IDW'(N_REQ - 1);
    localparam logic [IDW:0]   N_WIDE       = (IDW + 1)'(N_REQ);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   grant_inc;
    logic [IDW:0]     search_idx;
    logic             any_valid;
    logic [7:0]       tx_byte;
    logic [TW-1:0]    tmo_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             done_q;
    logic             done_rise;
    logic             timeout_hit;
    logic [N_REQ-1:0] grant_onehot;
    logic [N_REQ-1:0] done_pulse;
    logic             timeout_pulse;
    logic             unused_tx_active;

    // The transmitter's busy flag is status only; the FSM is paced purely by the done edge.
    assign unused_tx_active = bus.i_tx_active;

    assign done_rise    = bus.i_tx_done & ~done_q;
    assign timeout_hit  = (tmo_cnt == TIMEOUT_LAST);
    assign grant_inc    = (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;
    assign grant_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;

    // First valid requester at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        any_valid  = 1'b0;
        winner     = '0;
        search_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            search_idx = {1'b0, ptr} + (IDW + 1)'(i);
            if (search_idx >= N_WIDE) begin
                search_idx = search_idx - N_WIDE;
            end
            if (!any_valid && bus.i_req_valid[search_idx[IDW-1:0]]) begin
                any_valid = 1'b1;
                winner    = search_idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (any_valid) state_next = SEND;
            SEND:      state_next = WAIT_DONE;
            WAIT_DONE: if (done_rise || timeout_hit) state_next = GAP;
            GAP:       if (gap_cnt == GAP_LAST) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Done takes priority over the watchdog when both land on the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr           <= '0;
            grant_id      <= '0;
            tx_byte       <= '0;
            tmo_cnt       <= '0;
            gap_cnt       <= '0;
            done_q        <= 1'b0;
            done_pulse    <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            done_q        <= bus.i_tx_done;
            done_pulse    <= '0;
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant_id <= winner;
                        tx_byte  <= bus.i_req_byte[int'(winner)*8 +: 8];
                    end
                end
                SEND: begin
                    tmo_cnt <= '0;
                end
                WAIT_DONE: begin
                    if (done_rise) begin
                        done_pulse <= grant_onehot;
                        ptr        <= grant_inc;
                        gap_cnt    <= '0;
                    end else if (timeout_hit) begin
                        timeout_pulse <= 1'b1;
                        ptr           <= grant_inc;
                        gap_cnt       <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.o_tx_dv     = (state == SEND);
        bus.o_req_ready = (state == SEND) ? grant_onehot : '0;
        bus.o_busy      = (state != IDLE);
        bus.o_req_done  = done_pulse;
        bus.o_timeout   = timeout_pulse;
        bus.o_grant_id  = grant_id;
        bus.o_tx_byte   = tx_byte;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: instance A (gap 2, timeout 128) and instance B (gap 0, timeout 64).
// Stimulus pushes hand-timed expected events; a negedge monitor pops and compares whatever the DUTs emit.
module tb_uart_tx_arbiter;
    localparam int K_GRANT = 0;
    localparam int K_DONE  = 1;
    localparam int K_TMO   = 2;

    typedef struct {
        int         kind;
        int         inst;
        int         id;
        logic [7:0] byt;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    uart_tx_arbiter_if #(.N_REQ(4)) bus_a ();
    uart_tx_arbiter_if #(.N_REQ(4)) bus_b ();

    uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(128)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_a)
    );

    uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(64)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] onehot4(input int id);
        logic [3:0] one;
        one = 4'b0001;
        return one << id;
    endfunction

    task automatic push_exp(input int kind, input int inst, input int id, input logic [7:0] byt, input int c);
        exp_t e;
        e.kind = kind;
        e.inst = inst;
        e.id   = id;
        e.byt  = byt;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Pops one expected event and compares it with what an instance just emitted.
    task automatic match_event(input int inst, input int kind, input logic [3:0] mask,
                               input logic dv, input logic [7:0] byt, input logic [1:0] gid);
        exp_t e;
        logic ok;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL event: unexpected inst=%0d kind=%0d mask=%b byte=%0h cycle=%0d, none expected",
                     inst, kind, mask, byt, cyc);
            return;
        end
        e  = exp_q.pop_front();
        ok = (e.kind == kind) && (e.inst == inst) && (e.cyc == cyc);
        if (kind == K_GRANT) begin
            ok = ok && (mask == onehot4(e.id)) && dv && (byt == e.byt) && (gid == 2'(e.id));
        end else if (kind == K_DONE) begin
            ok = ok && (mask == onehot4(e.id));
        end
        if (!ok) begin
            errors++;
            $display("[TB] FAIL event: got inst=%0d kind=%0d mask=%b dv=%b byte=%0h gid=%0d cycle=%0d, expected inst=%0d kind=%0d id=%0d byte=%0h cycle=%0d",
                     inst, kind, mask, dv, byt, gid, cyc, e.inst, e.kind, e.id, e.byt, e.cyc);
        end
    endtask

    task automatic observe(input int inst, input logic [3:0] rdy, input logic dv, input logic [7:0] byt,
                           input logic [1:0] gid, input logic [3:0] dn, input logic tmo);
        if (rdy != 4'b0 || dv) match_event(inst, K_GRANT, rdy, dv, byt, gid);
        if (dn != 4'b0)        match_event(inst, K_DONE, dn, 1'b0, 8'h00, 2'b00);
        if (tmo)               match_event(inst, K_TMO, 4'b0, 1'b0, 8'h00, 2'b00);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            observe(0, bus_a.o_req_ready, bus_a.o_tx_dv, bus_a.o_tx_byte, bus_a.o_grant_id,
                    bus_a.o_req_done, bus_a.o_timeout);
            observe(1, bus_b.o_req_ready, bus_b.o_tx_dv, bus_b.o_tx_byte, bus_b.o_grant_id,
                    bus_b.o_req_done, bus_b.o_timeout);
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic logic [31:0] outs_a();
        return 32'({bus_a.o_busy, bus_a.o_tx_dv, bus_a.o_timeout, bus_a.o_req_ready,
                    bus_a.o_req_done, bus_a.o_grant_id, bus_a.o_tx_byte});
    endfunction

    function automatic logic [31:0] outs_b();
        return 32'({bus_b.o_busy, bus_b.o_tx_dv, bus_b.o_timeout, bus_b.o_req_ready,
                    bus_b.o_req_done, bus_b.o_grant_id, bus_b.o_tx_byte});
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic apply_stimulus();
        int         c;
        int         g;
        int         h;
        int         ids[3];
        logic [31:0] bytes;

        // Single requester 2, transmitter done 100 clocks after the strobe.
        c = cyc;
        g = c + 1;
        bus_a.i_req_byte  = 32'h00A5_0000;
        bus_a.i_req_valid = 4'b0100;
        push_exp(K_GRANT, 0, 2, 8'hA5, g);
        push_exp(K_DONE, 0, 2, 8'h00, g + 101);
        wait_until(g);
        bus_a.i_req_valid = 4'b0000;
        wait_until(g + 100);
        bus_a.i_tx_done = 1'b1;
        wait_until(g + 101);
        bus_a.i_tx_done = 1'b0;
        wait_until(g + 103);
        check_output("busy_in_gap", 32'(bus_a.o_busy), 32'd1);
        wait_until(g + 104);
        check_output("busy_after_gap", 32'(bus_a.o_busy), 32'd0);

        // All four requesters continuously valid from a reset pointer.
        apply_reset();
        bytes = 32'h4332_2110;
        c = cyc;
        bus_a.i_req_byte  = bytes;
        bus_a.i_req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push_exp(K_GRANT, 0, k % 4, bytes[8*(k%4) +: 8], c + 1 + 25*k);
            push_exp(K_DONE, 0, k % 4, 8'h00, c + 1 + 25*k + 21);
        end
        for (int k = 0; k < 5; k++) begin
            g = c + 1 + 25*k;
            wait_until(g);
            if (k == 4) bus_a.i_req_valid = 4'b0000;
            wait_until(g + 20);
            bus_a.i_tx_done = 1'b1;
            wait_until(g + 21);
            bus_a.i_tx_done = 1'b0;
        end
        wait_until(cyc + 5);

        // Done level already high on entry is ignored; only the later rising edge counts.
        c = cyc;
        bus_a.i_tx_done = 1'b1;
        wait_until(c + 2);
        bus_a.i_req_byte  = 32'h0000_5A00;
        bus_a.i_req_valid = 4'b0010;
        g = c + 3;
        push_exp(K_GRANT, 0, 1, 8'h5A, g);
        push_exp(K_DONE, 0, 1, 8'h00, g + 51);
        wait_until(g);
        bus_a.i_req_valid = 4'b0000;
        wait_until(g + 10);
        bus_a.i_tx_done = 1'b0;
        wait_until(g + 50);
        bus_a.i_tx_done = 1'b1;
        wait_until(g + 52);
        bus_a.i_tx_done = 1'b0;
        wait_until(g + 56);

        // Reset in the middle of WAIT_DONE, then requesters 0 and 1 from a fresh pointer.
        c = cyc;
        g = c + 1;
        bus_a.i_req_byte  = 32'h003C_0000;
        bus_a.i_req_valid = 4'b0100;
        push_exp(K_GRANT, 0, 2, 8'h3C, g);
        wait_until(g);
        bus_a.i_req_valid = 4'b0000;
        wait_until(g + 10);
        check_output("busy_before_reset", 32'(bus_a.o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("outputs_in_midframe_reset", outs_a(), 32'd0);
        wait_until(g + 12);
        rst_n = 1'b1;
        h = g + 13;
        bus_a.i_req_byte  = 32'h0000_2211;
        bus_a.i_req_valid = 4'b0011;
        push_exp(K_GRANT, 0, 0, 8'h11, h);
        push_exp(K_DONE, 0, 0, 8'h00, h + 4);
        push_exp(K_GRANT, 0, 1, 8'h22, h + 8);
        push_exp(K_DONE, 0, 1, 8'h00, h + 12);
        wait_until(h);
        bus_a.i_req_valid = 4'b0010;
        wait_until(h + 3);
        bus_a.i_tx_done = 1'b1;
        wait_until(h + 4);
        bus_a.i_tx_done = 1'b0;
        wait_until(h + 8);
        bus_a.i_req_valid = 4'b0000;
        wait_until(h + 11);
        bus_a.i_tx_done = 1'b1;
        wait_until(h + 12);
        bus_a.i_tx_done = 1'b0;
        wait_until(h + 16);

        // Instance B: transmitter never finishes, watchdog fires, pointer moves past requester 1.
        c = cyc;
        g = c + 1;
        bus_b.i_req_byte  = 32'h7300_7100;
        bus_b.i_req_valid = 4'b1010;
        push_exp(K_GRANT, 1, 1, 8'h71, g);
        push_exp(K_TMO, 1, 0, 8'h00, g + 65);
        push_exp(K_GRANT, 1, 3, 8'h73, g + 67);
        push_exp(K_DONE, 1, 3, 8'h00, g + 73);
        wait_until(g + 67);
        bus_b.i_req_valid = 4'b0000;
        wait_until(g + 72);
        bus_b.i_tx_done = 1'b1;
        wait_until(g + 73);
        bus_b.i_tx_done = 1'b0;
        wait_until(g + 76);

        // Instance B with zero gap: grants alternate 1,3,1 every frame time plus three clocks.
        c = cyc;
        bus_b.i_req_byte  = 32'h8300_8100;
        bus_b.i_req_valid = 4'b1010;
        ids = '{1, 3, 1};
        for (int k = 0; k < 3; k++) begin
            push_exp(K_GRANT, 1, ids[k], (ids[k] == 1) ? 8'h81 : 8'h83, c + 1 + 7*k);
            push_exp(K_DONE, 1, ids[k], 8'h00, c + 1 + 7*k + 5);
        end
        for (int k = 0; k < 3; k++) begin
            g = c + 1 + 7*k;
            wait_until(g);
            if (k == 2) bus_b.i_req_valid = 4'b0000;
            wait_until(g + 4);
            bus_b.i_tx_done = 1'b1;
            wait_until(g + 5);
            bus_b.i_tx_done = 1'b0;
        end
        wait_until(cyc + 5);
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_a.i_req_valid = '0;
        bus_a.i_req_byte  = '0;
        bus_a.i_tx_active = 1'b0;
        bus_a.i_tx_done   = 1'b0;
        bus_b.i_req_valid = '0;
        bus_b.i_req_byte  = '0;
        bus_b.i_tx_active = 1'b0;
        bus_b.i_tx_done   = 1'b0;
        #12;
        check_output("reset_outputs_a", outs_a(), 32'd0);
        check_output("reset_outputs_b", outs_b(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus();
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
